// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and helpers for the serial-in/parallel-out receiver.
// Optional feature macro: SIPO_PARITY_EN (adds the PAR state for a trailing
// even-parity bit).
package sipo_pkg;

  // Receiver FSM states; PAR only exists when a parity bit follows each word.
`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } sipo_state_t;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;
`endif

  // Bit counter must hold the values 0..w inclusive.
  function automatic int sipo_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_rx.sv
// sipo_rx: frames a qualified serial stream into W-bit words, MSB first.
// A word start (s) restarts framing at any time; each completed word is held
// on o and flagged by a one-cycle pulse on v.
// Optional feature macro: SIPO_PARITY_EN (one even-parity bit after each
// word, result reported on perr alongside o).
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i,
  input  logic         en,
  input  logic         s,
  output logic [W-1:0] o,
  output logic         v,
`ifdef SIPO_PARITY_EN
  output logic         perr,
`endif
  output logic         busy
);

  localparam int CW = sipo_cnt_width(W);

  sipo_state_t   state_reg;
  logic [W-1:0]  sr_reg;
  logic [CW-1:0] cnt_reg;

  logic [W-1:0]  shifted;
  logic [CW-1:0] cnt_next;
  logic          word_done;
  logic          take_bit;
  logic          unused_msb;

  // Shift register contents after taking the current bit at the LSB.
  // For W=1 the loop is empty and the word is just the incoming bit.
  assign shifted[0] = i;
  genvar gi;
  generate
    for (gi = 1; gi < W; gi++) begin : g_shift
      assign shifted[gi] = sr_reg[gi-1];
    end
  endgenerate

  // The MSB is shifted out, not consumed, when the word goes straight to o.
  assign unused_msb = sr_reg[W-1];

  // Decide whether this edge accepts a data bit and where the count lands.
  always_comb begin
    take_bit  = 1'b0;
    cnt_next  = cnt_reg + CW'(1);
    if (en) begin
      unique case (state_reg)
        IDLE:    take_bit = s;
        SHIFT:   take_bit = 1'b1;
        default: take_bit = s;   // PAR: only a restart takes a data bit
      endcase
    end
    // A start bit (or the first bit out of IDLE) always begins at count 1.
    if (s || state_reg == IDLE) begin
      cnt_next = CW'(1);
    end
    word_done = (cnt_next == CW'(W));
  end

  assign busy = (state_reg != IDLE);

  // Framing FSM with registered word, valid pulse and parity flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      o         <= '0;
      v         <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr      <= 1'b0;
`endif
    end else begin
      v <= 1'b0;
      if (take_bit) begin
        sr_reg <= shifted;
        if (word_done) begin
`ifdef SIPO_PARITY_EN
          state_reg <= PAR;
          cnt_reg   <= cnt_next;
`else
          o         <= shifted;
          v         <= 1'b1;
          state_reg <= IDLE;
          cnt_reg   <= '0;
`endif
        end else begin
          state_reg <= SHIFT;
          cnt_reg   <= cnt_next;
        end
      end
`ifdef SIPO_PARITY_EN
      else if (en && state_reg == PAR) begin
        // Parity bit accepted: deliver the word even when parity is bad.
        o         <= sr_reg;
        perr      <= (^sr_reg) ^ i;
        v         <= 1'b1;
        state_reg <= IDLE;
        cnt_reg   <= '0;
      end
`endif
    end
  end

endmodule
